wb_pixel_mem_slave: RTL and testbench



---
 rtl/wb_pkg.sv | 15 +
 rtl/pixel_ram_bank.sv | 40 ++++
 rtl/wb_pixel_mem_slave.sv | 136 +++++++++++++
 tb/tb_wb_pixel_mem_slave.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the Wishbone pixel memory slave.
package wb_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 18;
  localparam int LANES  = 4;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/pixel_ram_bank.sv
// Single-port byte-enabled pixel RAM with a registered read port.
module pixel_ram_bank
  import wb_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = 153600
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [LANES-1:0] be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];

  // Contents survive reset; only the read register clears.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_i[i]) begin
          mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_o <= '0;
    end else if (en_i && !we_i) begin
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/wb_pixel_mem_slave.sv
// Wishbone-classic single-beat slave fronting the Sobel image memory,
// with programmable wait states, range checking and access counters.
module wb_pixel_mem_slave
  import wb_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int AW          = AW_DEF,
  parameter int DEPTH       = 153600,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cyc_i,
  input  logic          stb_i,
  input  logic          we_i,
  input  logic [AW-1:0] adr_i,
  input  logic [3:0]    sel_i,
  input  logic [DW-1:0] dat_i,
  output logic [DW-1:0] dat_o,
  output logic          ack_o,
  output logic          err_o,
  output logic [31:0]   rd_cnt_o,
  output logic [31:0]   wr_cnt_o
);

  localparam logic [WAIT_W-1:0] WS = WAIT_W'(WAIT_STATES);

  state_t            state;
  logic [WAIT_W-1:0] cnt;
  logic [AW-1:0]     adr_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [DW-1:0]     dat_q;

  logic          req;
  logic          idle;
  logic [AW-1:0] c_adr;
  logic          c_we;
  logic [3:0]    c_sel;
  logic [DW-1:0] c_dat;
  logic          in_rng;
  logic          commit;

  assign req  = cyc_i & stb_i;
  assign idle = (state == IDLE);

  // Zero-wait requests commit on the sample edge, before the latch
  // holds anything, so the RAM sees the live bus in IDLE.
  assign c_adr  = idle ? adr_i : adr_q;
  assign c_we   = idle ? we_i  : we_q;
  assign c_sel  = idle ? sel_i : sel_q;
  assign c_dat  = idle ? dat_i : dat_q;
  assign in_rng = 32'(c_adr) < 32'(DEPTH);

  always_comb begin
    commit = 1'b0;
    unique case (1'b1)
      (state == IDLE): commit = req && (WS == '0);
      (state == WAIT): commit = req && (cnt == WAIT_W'(1));
      default:         commit = 1'b0;
    endcase
  end

  pixel_ram_bank #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (commit & in_rng),
    .we_i    (c_we),
    .be_i    (c_sel),
    .addr_i  (c_adr),
    .wdata_i (c_dat),
    .rdata_o (dat_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      adr_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      dat_q    <= '0;
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            adr_q <= adr_i;
            we_q  <= we_i;
            sel_q <= sel_i;
            dat_q <= dat_i;
            cnt   <= WS;
            if (commit) begin
              state <= RESP;
              ack_o <= in_rng;
              err_o <= !in_rng;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (commit) begin
            state <= RESP;
            cnt   <= '0;
            ack_o <= in_rng;
            err_o <= !in_rng;
          end else begin
            cnt <= cnt - WAIT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          if (ack_o) begin
            if (we_q) wr_cnt_o <= wr_cnt_o + 32'd1;
            else      rd_cnt_o <= rd_cnt_o + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_pixel_mem_slave.sv
// Bench for wb_pixel_mem_slave: three instances (0, 3, 4 wait states)
// checked every cycle against a transaction-level model.
module tb_wb_pixel_mem_slave;

  localparam int DEPTH = 153600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic        cyc [3];
  logic        stb [3];
  logic        we  [3];
  logic [17:0] adr [3];
  logic [3:0]  sel [3];
  logic [31:0] dat [3];
  logic [31:0] dato[3];
  logic        ack [3];
  logic        err [3];
  logic [31:0] rdc [3];
  logic [31:0] wrc [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_pixel_mem_slave #(
      .DW          (32),
      .AW          (18),
      .DEPTH       (DEPTH),
      .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 3 : 4)
    ) dut (
      .clk_i    (clk),
      .rst_ni   (rst[g]),
      .cyc_i    (cyc[g]),
      .stb_i    (stb[g]),
      .we_i     (we[g]),
      .adr_i    (adr[g]),
      .sel_i    (sel[g]),
      .dat_i    (dat[g]),
      .dat_o    (dato[g]),
      .ack_o    (ack[g]),
      .err_o    (err[g]),
      .rd_cnt_o (rdc[g]),
      .wr_cnt_o (wrc[g])
    );
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_n  = 0;
  bit chk_en = 0;

  // Transaction-level model state
  logic [31:0] mm [int];
  bit          pend [3];
  int          pcyc [3];
  bit          perr [3];
  bit          pwe  [3];
  logic [31:0] pdat [3];
  logic [31:0] mlast[3];
  logic [31:0] mrd  [3];
  logic [31:0] mwr  [3];

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 3 : 4;
  endfunction

  function automatic int key_of(input int k, input logic [17:0] a);
    return k * (1 << 20) + int'(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               nm, act, exp, cyc_n);
    end
  endtask

  task automatic model_reset(input int k);
    pend[k]  = 0;
    mlast[k] = '0;
    mrd[k]   = '0;
    mwr[k]   = '0;
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        bit win, ea, ee;
        win = pend[k] && (cyc_n == pcyc[k]);
        ea  = win && !perr[k];
        ee  = win && perr[k];
        if (ea && !pwe[k]) mlast[k] = pdat[k];
        chk($sformatf("ack%0d", k), 32'(ack[k]), 32'(ea));
        chk($sformatf("err%0d", k), 32'(err[k]), 32'(ee));
        chk($sformatf("dat%0d", k), dato[k], mlast[k]);
        chk($sformatf("rdcnt%0d", k), rdc[k], mrd[k]);
        chk($sformatf("wrcnt%0d", k), wrc[k], mwr[k]);
        if (win) begin
          if (ea && pwe[k])  mwr[k] = mwr[k] + 1;
          if (ea && !pwe[k]) mrd[k] = mrd[k] + 1;
          pend[k] = 0;
        end
      end
    end
  end

  task automatic start(input int k, input bit w, input logic [17:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       output int n0);
    @(negedge clk);
    n0     = cyc_n + 1;
    cyc[k] = 1'b1;
    stb[k] = 1'b1;
    we[k]  = w;
    adr[k] = a;
    sel[k] = s;
    dat[k] = d;
    @(posedge clk);
  endtask

  task automatic do_req(input int k, input bit w, input logic [17:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        input bit keep, output logic [31:0] rd,
                        output int n0);
    int key;
    logic [31:0] v;
    start(k, w, a, s, d, n0);
    key     = key_of(k, a);
    pend[k] = 1;
    pcyc[k] = n0 + ws_of(k);
    perr[k] = int'(a) >= DEPTH;
    pwe[k]  = w;
    pdat[k] = '0;
    if (!perr[k]) begin
      v = mm.exists(key) ? mm[key] : '0;
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (s[i]) v[8*i +: 8] = d[8*i +: 8];
        mm[key] = v;
      end else begin
        pdat[k] = v;
      end
    end
    repeat (ws_of(k) + 1) @(negedge clk);
    rd = dato[k];
    // Scramble the bus to show the latched copy is used.
    adr[k] = ~a;
    dat[k] = ~d;
    if (!keep) begin
      cyc[k] = 1'b0;
      stb[k] = 1'b0;
    end
  endtask

  logic [31:0] rv;
  int          n0, na, nb, nc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected done");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      adr[k] = '0; sel[k] = '0; dat[k] = '0;
      model_reset(k);
    end
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    #2 chk_en = 1;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;

    // Zero wait states: write then read back.
    do_req(0, 1, 18'd5, 4'hF, 32'hA1B2C3D4, 0, rv, n0);
    do_req(0, 0, 18'd5, 4'h0, 32'h0, 0, rv, n0);
    chk("rd5_lit", rv, 32'hA1B2C3D4);
    @(negedge clk);
    chk("wr_cnt_lit", wrc[0], 32'd1);
    chk("rd_cnt_lit", rdc[0], 32'd1);

    // Byte-lane write and zero-select write.
    do_req(0, 1, 18'd7, 4'hF, 32'h11223344, 0, rv, n0);
    do_req(0, 1, 18'd7, 4'b0101, 32'hFFFFFFFF, 0, rv, n0);
    do_req(0, 1, 18'd7, 4'b0000, 32'h00000000, 0, rv, n0);
    do_req(0, 0, 18'd7, 4'h0, 32'h0, 0, rv, n0);
    chk("sel_lit", rv, 32'h11FF33FF);

    // Range boundary.
    do_req(0, 1, 18'(DEPTH - 1), 4'hF, 32'h0BADF00D, 0, rv, n0);
    do_req(0, 0, 18'(DEPTH - 1), 4'h0, 32'h0, 0, rv, n0);
    chk("top_lit", rv, 32'h0BADF00D);
    do_req(0, 0, 18'(DEPTH), 4'h0, 32'h0, 0, rv, n0);
    chk("err_hold_lit", rv, 32'h0BADF00D);
    do_req(0, 1, 18'(DEPTH + 9), 4'hF, 32'h12345678, 0, rv, n0);
    do_req(0, 0, 18'd5, 4'h0, 32'h0, 0, rv, n0);
    chk("after_err_lit", rv, 32'hA1B2C3D4);
    @(negedge clk);
    chk("wr_cnt_err_lit", wrc[0], 32'd5);
    chk("rd_cnt_err_lit", rdc[0], 32'd4);

    // Three wait states: row reads with cyc held high.
    for (int i = 0; i < 3; i++)
      do_req(1, 1, 18'(100 + i), 4'hF, 32'h01010101 * (i + 1), 0, rv, n0);
    do_req(1, 0, 18'd100, 4'h0, 32'h0, 1, rv, na);
    do_req(1, 0, 18'd101, 4'h0, 32'h0, 1, rv, nb);
    chk("row_lit", rv, 32'h02020202);
    do_req(1, 0, 18'd102, 4'h0, 32'h0, 0, rv, nc);
    chk("period_ab", 32'(nb - na), 32'd5);
    chk("period_bc", 32'(nc - nb), 32'd5);

    // Reset during a write's wait phase.
    do_req(1, 1, 18'd10, 4'hF, 32'hCAFEF00D, 0, rv, n0);
    start(1, 1, 18'd10, 4'hF, 32'hDEADBEEF, n0);
    @(negedge clk);
    #1;
    rst[1] = 1'b0;
    model_reset(1);
    #1;
    chk("rst_ack", 32'(ack[1]), 32'd0);
    chk("rst_dat", dato[1], 32'd0);
    chk("rst_rd", rdc[1], 32'd0);
    chk("rst_wr", wrc[1], 32'd0);
    cyc[1] = 1'b0;
    stb[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    do_req(1, 0, 18'd10, 4'h0, 32'h0, 0, rv, n0);
    chk("rst_keep_lit", rv, 32'hCAFEF00D);

    // Four wait states: strobe dropped in the second wait cycle.
    do_req(2, 1, 18'd20, 4'hF, 32'h55AA55AA, 0, rv, n0);
    start(2, 1, 18'd20, 4'hF, 32'h00000000, n0);
    @(negedge clk);
    @(negedge clk);
    stb[2] = 1'b0;
    cyc[2] = 1'b0;
    do_req(2, 0, 18'd20, 4'h0, 32'h0, 0, rv, n0);
    chk("abort_lit", rv, 32'h55AA55AA);
    @(negedge clk);
    chk("abort_wr_lit", wrc[2], 32'd1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
